// File: rtl/data_stream_width_conv.sv
// data_stream_width_conv
// ----------------------
// Width converter for a valid/ready data stream that carries data, byte
// strobes and a packet-end flag (last).
//   OUT_WIDTH > IN_WIDTH : packs N narrow beats into one wide word (upsize).
//   OUT_WIDTH < IN_WIDTH : splits one wide word into N narrow beats (downsize).
//   OUT_WIDTH = IN_WIDTH : single registered slice.
// Lanes are little-endian: lane k is bits [k*W +: W] and goes first when k
// is lowest. All m_* outputs come straight from flops.
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   s_data   slave data            [IN_WIDTH]
//   s_strb   slave byte strobe     [IN_WIDTH/8]
//   s_last   slave end-of-packet
//   s_valid  slave valid
//   s_ready  slave ready (may depend combinationally on m_ready)
//   m_data   master data           [OUT_WIDTH]
//   m_strb   master byte strobe    [OUT_WIDTH/8]
//   m_last   master end-of-packet
//   m_valid  master valid
//   m_ready  master ready
module data_stream_width_conv #(
  parameter int IN_WIDTH   = 32,
  parameter int OUT_WIDTH  = 128,
  parameter bit DROP_EMPTY = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IN_WIDTH-1:0]    s_data,
  input  logic [IN_WIDTH/8-1:0]  s_strb,
  input  logic                   s_last,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [OUT_WIDTH-1:0]   m_data,
  output logic [OUT_WIDTH/8-1:0] m_strb,
  output logic                   m_last,
  output logic                   m_valid,
  input  logic                   m_ready
);

  localparam int IN_BYTES  = IN_WIDTH / 8;
  localparam int OUT_BYTES = OUT_WIDTH / 8;
  // One output slice worth of strobe bits, positioned at slice 0 of s_strb.
  localparam logic [IN_BYTES-1:0] SLICE_MASK = IN_BYTES'((64'd1 << OUT_BYTES) - 64'd1);

  logic                 en_r;
  logic [OUT_WIDTH-1:0] m_data_r;
  logic [OUT_BYTES-1:0] m_strb_r;
  logic                 m_last_r;
  logic                 m_valid_r;
  logic                 s_ready_s;

  assign m_data  = m_data_r;
  assign m_strb  = m_strb_r;
  assign m_last  = m_last_r;
  assign m_valid = m_valid_r;
  assign s_ready = s_ready_s;

  // Index of the last slice to emit for a downsized word. With DROP_EMPTY on
  // a last word, trailing all-zero-strobe slices are skipped; an all-zero
  // word still produces slice 0.
  function automatic int final_slice(input logic [IN_BYTES-1:0] strb, input logic last);
    int n;
    int fin;
    n = (OUT_WIDTH < IN_WIDTH) ? (IN_WIDTH / OUT_WIDTH) : 1;
    if (DROP_EMPTY && last) begin
      fin = 0;
      for (int k = 0; k < n; k++) begin
        if (|((strb >> (k * OUT_BYTES)) & SLICE_MASK)) begin
          fin = k;
        end else begin
          fin = fin;
        end
      end
    end else begin
      fin = n - 1;
    end
    return fin;
  endfunction

  // Ready enable: low through reset, high from the first cycle after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_r <= 1'b0;
    end else begin
      en_r <= 1'b1;
    end
  end

  if ((IN_WIDTH % 8 != 0) || (OUT_WIDTH % 8 != 0) ||
      ((IN_WIDTH % OUT_WIDTH != 0) && (OUT_WIDTH % IN_WIDTH != 0))) begin : g_bad_cfg
    $error("data_stream_width_conv: widths must be byte multiples and integer multiples of each other");
  end

  if (OUT_WIDTH == IN_WIDTH) begin : g_pass

    // Ready whenever the output slot is empty or emptying this cycle.
    always_comb begin
      s_ready_s = en_r && !rst && (!m_valid_r || m_ready);
    end

    // One-entry register slice.
    always_ff @(posedge clk) begin
      if (rst) begin
        m_valid_r <= 1'b0;
        m_data_r  <= '0;
        m_strb_r  <= '0;
        m_last_r  <= 1'b0;
      end else if (s_valid && s_ready_s) begin
        m_valid_r <= 1'b1;
        m_data_r  <= s_data;
        m_strb_r  <= s_strb;
        m_last_r  <= s_last;
      end else if (m_ready) begin
        m_valid_r <= 1'b0;
      end else begin
        m_valid_r <= m_valid_r;
      end
    end

  end else if (OUT_WIDTH > IN_WIDTH) begin : g_up

    localparam int N  = OUT_WIDTH / IN_WIDTH;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [OUT_WIDTH-1:0] acc_data_r;
    logic [OUT_BYTES-1:0] acc_strb_r;
    logic [CW-1:0]        cnt_r;
    logic [OUT_WIDTH-1:0] word_data_s;
    logic [OUT_BYTES-1:0] word_strb_s;
    logic                 accept_s;
    logic                 complete_s;

    // Merge the incoming beat into the accumulator at the current lane.
    // Lanes above cnt are always zero, so a word closed early by last
    // carries zero data and zero strobe in its unwritten lanes.
    always_comb begin
      s_ready_s   = en_r && !rst && (!m_valid_r || m_ready);
      accept_s    = s_valid && s_ready_s;
      complete_s  = (cnt_r == CW'(N - 1)) || s_last;
      word_data_s = acc_data_r;
      word_data_s[cnt_r * IN_WIDTH +: IN_WIDTH] = s_data;
      word_strb_s = acc_strb_r;
      word_strb_s[cnt_r * IN_BYTES +: IN_BYTES] = s_strb;
    end

    // Accumulator and lane counter.
    always_ff @(posedge clk) begin
      if (rst) begin
        acc_data_r <= '0;
        acc_strb_r <= '0;
        cnt_r      <= '0;
      end else if (accept_s && complete_s) begin
        acc_data_r <= '0;
        acc_strb_r <= '0;
        cnt_r      <= '0;
      end else if (accept_s) begin
        acc_data_r <= word_data_s;
        acc_strb_r <= word_strb_s;
        cnt_r      <= cnt_r + 1'b1;
      end else begin
        cnt_r      <= cnt_r;
      end
    end

    // Output register: the completing beat goes straight into it.
    always_ff @(posedge clk) begin
      if (rst) begin
        m_valid_r <= 1'b0;
        m_data_r  <= '0;
        m_strb_r  <= '0;
        m_last_r  <= 1'b0;
      end else if (accept_s && complete_s) begin
        m_valid_r <= 1'b1;
        m_data_r  <= word_data_s;
        m_strb_r  <= word_strb_s;
        m_last_r  <= s_last;
      end else if (m_ready) begin
        m_valid_r <= 1'b0;
      end else begin
        m_valid_r <= m_valid_r;
      end
    end

  end else begin : g_down

    localparam int N  = IN_WIDTH / OUT_WIDTH;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [0:0] {IDLE, SPLIT} state_t;

    state_t               state_r;
    state_t               state_nx;
    logic [IN_WIDTH-1:0]  word_r;
    logic [IN_BYTES-1:0]  strb_r;
    logic                 last_r;
    logic [IW-1:0]        idx_r;
    logic [IW-1:0]        fin_r;
    logic [IW-1:0]        fin_s;
    logic [IW-1:0]        nxt_idx_s;
    logic                 m_xfer_s;
    logic                 at_final_s;
    logic                 load_s;
    logic                 adv_s;

    // Next state and handshake control. While splitting, a new word is only
    // taken on the handshake of the final slice so words stream without a
    // bubble.
    always_comb begin
      state_nx   = state_r;
      s_ready_s  = 1'b0;
      m_xfer_s   = m_valid_r && m_ready;
      at_final_s = (idx_r == fin_r);
      nxt_idx_s  = idx_r + 1'b1;
      fin_s      = IW'(final_slice(s_strb, s_last));
      case (state_r)
        IDLE: begin
          s_ready_s = en_r && !rst && (!m_valid_r || m_ready);
          if (s_valid && s_ready_s) begin
            state_nx = SPLIT;
          end else begin
            state_nx = IDLE;
          end
        end
        SPLIT: begin
          s_ready_s = en_r && !rst && at_final_s && m_ready;
          if (m_xfer_s && at_final_s && !(s_valid && s_ready_s)) begin
            state_nx = IDLE;
          end else begin
            state_nx = SPLIT;
          end
        end
        default: begin
          s_ready_s = 1'b0;
          state_nx  = IDLE;
        end
      endcase
      load_s = s_valid && s_ready_s;
      adv_s  = (state_r == SPLIT) && m_xfer_s && !at_final_s;
    end

    // State register.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_r <= IDLE;
      end else begin
        state_r <= state_nx;
      end
    end

    // Word latch, slice index and output register.
    always_ff @(posedge clk) begin
      if (rst) begin
        word_r    <= '0;
        strb_r    <= '0;
        last_r    <= 1'b0;
        idx_r     <= '0;
        fin_r     <= '0;
        m_valid_r <= 1'b0;
        m_data_r  <= '0;
        m_strb_r  <= '0;
        m_last_r  <= 1'b0;
      end else if (load_s) begin
        word_r    <= s_data;
        strb_r    <= s_strb;
        last_r    <= s_last;
        idx_r     <= '0;
        fin_r     <= fin_s;
        m_valid_r <= 1'b1;
        m_data_r  <= s_data[OUT_WIDTH-1:0];
        m_strb_r  <= s_strb[OUT_BYTES-1:0];
        m_last_r  <= s_last && (fin_s == '0);
      end else if (adv_s) begin
        idx_r     <= nxt_idx_s;
        m_data_r  <= word_r[nxt_idx_s * OUT_WIDTH +: OUT_WIDTH];
        m_strb_r  <= strb_r[nxt_idx_s * OUT_BYTES +: OUT_BYTES];
        m_last_r  <= last_r && (nxt_idx_s == fin_r);
      end else if (m_xfer_s) begin
        m_valid_r <= 1'b0;
      end else begin
        m_valid_r <= m_valid_r;
      end
    end

  end

endmodule

// File: doc/data_stream_width_conv.md
Name: data_stream_width_conv

Overview:
- Parametrised width converter for the team's valid/ready data stream (data + byte strobe), extended with a packet-end flag (last).
- Packs narrow beats into wide words (upsize) or splits wide words into narrow beats (downsize). With equal widths it acts as a single register stage.
- Sits between stream masters and slaves of differing bus width, e.g. a 32-bit datapath feeding a 128-bit AXI-side buffer.

Parameters:
- IN_WIDTH, 32, slave-side data width in bits; multiple of 8.
- OUT_WIDTH, 128, master-side data width in bits; multiple of 8. One of IN_WIDTH/OUT_WIDTH must be an integer multiple of the other; otherwise elaboration fails via $error.
- DROP_EMPTY, 1, downsize only: on a last word, skip trailing slices whose strobe is all zero.

Ports:
- clk  input  1  single clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- s_data  input  IN_WIDTH  slave data.
- s_strb  input  IN_WIDTH/8  slave byte strobe.
- s_last  input  1  slave end-of-packet.
- s_valid  input  1  slave valid.
- s_ready  output  1  slave ready.
- m_data  output  OUT_WIDTH  master data.
- m_strb  output  OUT_WIDTH/8  master byte strobe.
- m_last  output  1  master end-of-packet.
- m_valid  output  1  master valid.
- m_ready  input  1  master ready.

Behaviour:
- Handshake and stability:
  - A transfer occurs on a rising edge with valid&&ready.
  - m_valid never drops without a transfer.
  - m_data/m_strb/m_last are stable while m_valid && !m_ready.
  - s_ready may depend combinationally on m_ready. No combinational path from s_* to m_*; all outputs are registered.
- Reset: m_valid=0, m_data=0, m_strb=0, m_last=0. Lane counter=0, accumulator cleared. s_ready=0 during rst and goes high the cycle after rst deasserts. Reset mid-packet discards all partial state with no output.
- Lane ordering: little-endian. Lane k occupies bits [k*W +: W], with the lowest lane first in time.
- Equal widths (N=1): one-entry register slice.
  - s_ready = !m_valid || m_ready.
  - Latency is 1 cycle; full throughput.
- Upsize (N = OUT_WIDTH/IN_WIDTH):
  - Accumulator with lane counter 0..N-1.
  - Each accepted beat is written to lane[cnt] along with its strb; cnt increments.
  - The word is complete when cnt==N-1 or s_last=1. On completion, the accumulator loads the output register the same edge: m_valid=1 next cycle, m_last=s_last, cnt reset to 0.
  - Lanes not written in a partial (early-last) word carry strb=0 and data=0.
  - s_ready = !m_valid || m_ready. A completing beat may be accepted in the same cycle the previous word transfers.
  - Throughput: one output word per N input cycles. Latency from the completing beat to m_valid is 1 cycle.
- Downsize (N = IN_WIDTH/OUT_WIDTH):
  - States IDLE and SPLIT.
  - IDLE: s_ready=1 when output reg is free or draining. On accept, latch the word, strb and last, set slice idx=0, present slice 0 next cycle, go to SPLIT.
  - SPLIT: s_ready=0, except on the final slice handshake, where s_ready=m_ready. This allows back-to-back words with no bubble.
  - Each m handshake advances idx.
  - The final slice is idx==N-1. If DROP_EMPTY && latched last, the final slice is instead the highest slice with a nonzero strobe; an all-zero word then yields a single slice 0.
  - m_last=1 only on the final slice of a last word. After the final slice, return to IDLE or reload directly.
  - Throughput: N output beats per input word.
- Simultaneous events: an output transfer and new-word load in the same cycle are both honoured; the register reloads with no gap. rst overrides everything.
- strb content is passed through unmodified, including sparse patterns. The block neither checks nor compacts strobes, except for the DROP_EMPTY trailing-slice rule.

Test Plan:
- Upsize 32->128, beats 0x11111111..0x44444444 strb 0xF, last on the 4th, m_ready=1 -> one word 0x44444444_33333333_22222222_11111111, strb 0xFFFF, m_last=1, m_valid 1 cycle after the 4th accept.
- Upsize early last: 2 beats 0xAAAA0001, 0xAAAA0002 with last on the 2nd -> m_data=0x00000000_00000000_AAAA0002_AAAA0001, m_strb=0x00FF, m_last=1; the next packet starts at lane 0.
- Downsize 128->32, word 0x44444444_33333333_22222222_11111111 strb 0xFFFF last=1, m_ready toggled 1,0,1,0... -> beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 in order, data stable while stalled, m_last only on the 4th; s_ready low for the first 3 slices.
- Downsize DROP_EMPTY=1, last word with strb=0x00FF -> exactly 2 beats, the 2nd with m_last=1. With DROP_EMPTY=0 -> 4 beats, the last two strb=0, m_last on the 4th.
- Back-to-back streaming, equal widths 64->64, s_valid=1 and m_ready=1 for 16 beats -> 16 transfers in 16 consecutive cycles after 1 cycle latency. Holding m_ready=0 for 3 cycles stalls with no loss or duplication.
- Reset mid-packet: upsize after 2 of 4 beats, assert rst for 1 cycle -> m_valid=0 and no output. The next 4 beats form a complete word starting at lane 0.
